// File: rtl/whack_pkg.sv
// Shared constants and types for the whack-a-mole input front-end.
package whack_pkg;

  localparam int N_SW = 18;
  localparam int N_BT = 4;

  // 20 ms at 50 MHz; the counter width must cover DEBOUNCE_CYCLES-1.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
  localparam int CNT_W_DEFAULT           = 20;

  typedef enum logic [2:0] {
    LVL_IDLE = 3'd0,
    LVL_1    = 3'd1,
    LVL_2    = 3'd2,
    LVL_3    = 3'd3,
    LVL_4    = 3'd4
  } level_t;

  // Maps a one-hot button press onto the level it selects (BT0 -> level 1).
  function automatic level_t button_level(input logic [N_BT-1:0] press);
    level_t lvl;
    lvl = LVL_IDLE;
    if (press[0])      lvl = LVL_1;
    else if (press[1]) lvl = LVL_2;
    else if (press[2]) lvl = LVL_3;
    else if (press[3]) lvl = LVL_4;
    return lvl;
  endfunction

endpackage

// File: rtl/whack_input_conditioner_if.sv
// Conditioned inputs handed from the front-end to the game core.
interface whack_input_conditioner_if;
  import whack_pkg::*;

  logic [N_SW-1:0] sw_stable;
  logic            sw_changed;
  logic [N_BT-1:0] bt_level;
  logic [N_BT-1:0] bt_press;
  logic            lvl_req;
  level_t          lvl_code;

  modport master (
    output sw_stable, sw_changed, bt_level, bt_press, lvl_req, lvl_code
  );

  modport slave (
    input sw_stable, sw_changed, bt_level, bt_press, lvl_req, lvl_code
  );

endinterface

// File: rtl/debounce_cell.sv
// Two-flop synchroniser followed by a stability counter.  The accepted
// value only moves once the synchronised input has held one value, different
// from the accepted one, for DEBOUNCE_CYCLES consecutive cycles.  The whole
// WIDTH-bit vector is treated as a single unit.
module debounce_cell #(
  parameter int               WIDTH           = 1,
  parameter int               DEBOUNCE_CYCLES = 1000000,
  parameter int               CNT_W           = 20,
  parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable,
  output logic             changed
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] stage1;
  logic [WIDTH-1:0] stage2;
  logic [WIDTH-1:0] stage2_prev;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] run;

  // Synchroniser chain plus a copy of the last synchronised value for change detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage1      <= RESET_VAL;
      stage2      <= RESET_VAL;
      stage2_prev <= RESET_VAL;
    end else begin
      stage1      <= raw;
      stage2      <= stage1;
      stage2_prev <= stage2;
    end
  end

  // Run length already accumulated for the current value; a fresh value starts from zero.
  always_comb begin
    run = '0;
    if (stage2 == stage2_prev) begin
      run = count;
    end
  end

  // Count stable cycles and accept the new value on the last one; count never passes LAST.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      stable  <= RESET_VAL;
      changed <= 1'b0;
    end else begin
      changed <= 1'b0;
      if (stage2 == stable) begin
        count <= '0;
      end else if (run == LAST) begin
        stable  <= stage2;
        changed <= 1'b1;
        count   <= '0;
      end else begin
        count <= run + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/whack_input_conditioner.sv
// Front-end for the whack-a-mole game core: debounces the slide switches as
// one vector and each push-button on its own, derives press pulses, and turns
// a lone button press into a registered level-select request.
module whack_input_conditioner
  import whack_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_SW-1:0]           sw_raw,
  input  logic [N_BT-1:0]           bt_n_raw,
  whack_input_conditioner_if.master core
);

  logic [N_SW-1:0] sw_stable;
  logic            sw_changed;
  logic [N_BT-1:0] bt_released;
  logic [N_BT-1:0] bt_flip;
  logic [N_BT-1:0] bt_level;
  logic [N_BT-1:0] bt_press;
  logic            single_press;
  logic            lvl_req;
  level_t          lvl_code;

  debounce_cell #(
    .WIDTH           (N_SW),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W),
    .RESET_VAL       ({N_SW{1'b0}})
  ) u_sw_debounce (
    .clk     (clk),
    .rst     (rst),
    .raw     (sw_raw),
    .stable  (sw_stable),
    .changed (sw_changed)
  );

  // Buttons idle high, so each cell resets to "released" and is inverted afterwards.
  for (genvar i = 0; i < N_BT; i++) begin : g_bt
    debounce_cell #(
      .WIDTH           (1),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .RESET_VAL       (1'b1)
    ) u_bt_debounce (
      .clk     (clk),
      .rst     (rst),
      .raw     (bt_n_raw[i]),
      .stable  (bt_released[i]),
      .changed (bt_flip[i])
    );
  end

  assign bt_level = ~bt_released;
  assign bt_press = bt_flip & bt_level;

  // A request needs exactly one new press and no other button already held.
  assign single_press = $onehot(bt_press) && (bt_level == bt_press);

  // Register the level request one cycle after the press; the code holds between requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_req  <= 1'b0;
      lvl_code <= LVL_IDLE;
    end else begin
      lvl_req <= single_press;
      if (single_press) begin
        lvl_code <= button_level(bt_press);
      end
    end
  end

  assign core.sw_stable  = sw_stable;
  assign core.sw_changed = sw_changed;
  assign core.bt_level   = bt_level;
  assign core.bt_press   = bt_press;
  assign core.lvl_req    = lvl_req;
  assign core.lvl_code   = lvl_code;

endmodule
